exception_unit: RTL and testbench

Trap and return sequencer that sits directly upstream of the CP0 register block. It accepts decoded `syscall`/`break`/`teq` trap requests and `eret` from the decode stage, gates them with CP0 Status, and drives the CP0 write strobes `wepc`/`wcau`/`wsta` plus the `exception`, `pc` and `cause` inputs over a fixed multi-cycle sequence. It then redirects the fetch PC to the handler vector, or back to EPC on `eret`, and stalls the pipeline while the sequence runs.

---
 rtl/exception_unit.sv | 125 ++++++++++++
 tb/tb_exception_unit.sv | 180 ++++++++++++++++++
 2 files changed

// File: rtl/exception_unit.sv
// Trap/return sequencer driving the CP0 write strobes and fetch redirect.
// Optional external interrupt source enabled by defining EXC_EXT_INT_EN.
module exception_unit #(
   parameter logic [31:0] VECTOR = 32'h0000_0004
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        syscall,
   input  logic        brk,
   input  logic        teq,
   input  logic        eret,
`ifdef EXC_EXT_INT_EN
   input  logic        int_req,
`endif
   input  logic [31:0] inst_pc,
   input  logic [31:0] status,
   input  logic [31:0] epc,
   output logic        exception,
   output logic        wepc,
   output logic        wcau,
   output logic        wsta,
   output logic [31:0] pc,
   output logic [31:0] cause,
   output logic        stall,
   output logic        redirect,
   output logic [31:0] redirect_pc,
   output logic [2:0]  fsm_state
);

   typedef enum logic [2:0] {
      S_IDLE    = 3'd0,
      S_SAVE    = 3'd1,
      S_JUMP    = 3'd2,
      S_RESTORE = 3'd3,
      S_RETURN  = 3'd4
   } state_t;

   state_t      state, next_state;
   logic [31:0] pc_q;
   logic [4:0]  code_q;
   logic        take_trap;
   logic        take_eret;
   logic [4:0]  trap_code;
   logic        unused_status;

   // Masked traps do not compete: the highest enabled request wins.
   always_comb begin
      take_trap = 1'b0;
      take_eret = 1'b0;
      trap_code = 5'b00000;
      if (state == S_IDLE && !rst) begin
         if (syscall && status[0] && status[1]) begin
            take_trap = 1'b1;
            trap_code = 5'b01000;
         end else if (brk && status[0] && status[2]) begin
            take_trap = 1'b1;
            trap_code = 5'b01001;
         end else if (teq && status[0] && status[3]) begin
            take_trap = 1'b1;
            trap_code = 5'b01101;
         end else if (eret) begin
            take_eret = 1'b1;
`ifdef EXC_EXT_INT_EN
         end else if (int_req && status[0] && status[4]) begin
            take_trap = 1'b1;
            trap_code = 5'b00000;
`endif
         end
      end
   end

`ifdef EXC_EXT_INT_EN
   assign unused_status = ^status[31:5];
`else
   assign unused_status = ^status[31:4];
`endif

   always_ff @(posedge clk) begin
      if (rst) begin
         state  <= S_IDLE;
         pc_q   <= 32'h0;
         code_q <= 5'b00000;
      end else begin
         state <= next_state;
         if (take_trap) begin
            pc_q   <= inst_pc;
            code_q <= trap_code;
         end
      end
   end

   always_comb begin
      next_state = state;
      case (state)
         S_IDLE: begin
            if (take_trap)      next_state = S_SAVE;
            else if (take_eret) next_state = S_RESTORE;
         end
         S_SAVE:    next_state = S_JUMP;
         S_JUMP:    next_state = S_IDLE;
         S_RESTORE: next_state = S_RETURN;
         S_RETURN:  next_state = S_IDLE;
         default:   next_state = S_IDLE;
      endcase
   end

   always_comb begin
      exception   = (state == S_SAVE);
      wepc        = (state == S_SAVE);
      wcau        = (state == S_SAVE);
      wsta        = (state == S_SAVE) || (state == S_RESTORE);
      stall       = (state == S_SAVE) || (state == S_RESTORE) || take_trap || take_eret;
      redirect    = (state == S_JUMP) || (state == S_RETURN);
      redirect_pc = 32'h0;
      if (state == S_JUMP)
         redirect_pc = VECTOR;
      else if (state == S_RETURN)
         redirect_pc = epc;
   end

   assign pc        = pc_q;
   assign cause     = {25'b0, code_q, 2'b00};
   assign fsm_state = state;

endmodule

// File: tb/tb_exception_unit.sv
// Scoreboard bench for exception_unit: directed cases then random requests
// against a phase-schedule reference model.
module tb_exception_unit;
   localparam int W = 102;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic        rst, syscall, brk, teq, eret, int_req;
   logic [31:0] inst_pc, status, epc;
   logic        exception, wepc, wcau, wsta, stall, redirect;
   logic [31:0] pc, cause, redirect_pc;
   logic [2:0]  fsm_state;

   exception_unit #(.VECTOR(32'h0000_0004)) dut (
      .clk(clk), .rst(rst), .syscall(syscall), .brk(brk), .teq(teq), .eret(eret),
`ifdef EXC_EXT_INT_EN
      .int_req(int_req),
`endif
      .inst_pc(inst_pc), .status(status), .epc(epc),
      .exception(exception), .wepc(wepc), .wcau(wcau), .wsta(wsta),
      .pc(pc), .cause(cause), .stall(stall), .redirect(redirect),
      .redirect_pc(redirect_pc), .fsm_state(fsm_state)
   );

   typedef struct {
      bit exc, we, wc, ws, stl, redir, to_vec, to_epc;
   } phase_t;

   phase_t      sched[$];
   logic [W-1:0] exp_q[$];
   logic [31:0] m_pc, m_cause;
   int          checks, errors;
   logic [W-1:0] mon_exp, mon_act;

   // Monitor: every cycle the DUT presents a full output tuple.
   always @(negedge clk) begin
      if (exp_q.size() > 0) begin
         mon_exp = exp_q.pop_front();
         mon_act = {exception, wepc, wcau, wsta, stall, redirect, pc, cause, redirect_pc};
         checks++;
         if (mon_act !== mon_exp) begin
            errors++;
            $display("FAIL outputs t=%0t actual exc/we/wc/ws/stall/redir=%b pc=%h cause=%h rpc=%h required %b pc=%h cause=%h rpc=%h",
                     $time, mon_act[101:96], mon_act[95:64], mon_act[63:32], mon_act[31:0],
                     mon_exp[101:96], mon_exp[95:64], mon_exp[63:32], mon_exp[31:0]);
         end
      end
   end

   // Drive one cycle of inputs and push the expected outputs for that cycle.
   task automatic cyc(input logic r, input logic sc, input logic bk, input logic tq,
                      input logic er, input logic ir, input logic [31:0] ipc,
                      input logic [31:0] st, input logic [31:0] ep);
      phase_t cur, p1, p2;
      bit trap, ret;
      logic [4:0] code;
      logic [31:0] rpc;
      @(posedge clk);
      #1;
      rst = r; syscall = sc; brk = bk; teq = tq; eret = er; int_req = ir;
      inst_pc = ipc; status = st; epc = ep;
      cur = '{default: 0};
      p1 = '{default: 0};
      p2 = '{default: 0};
      trap = 0; ret = 0; code = 5'd0;
      if (sched.size() > 0) begin
         cur = sched.pop_front();
      end else if (!r) begin
         if (sc && st[0] && st[1]) begin trap = 1; code = 5'b01000; end
         else if (bk && st[0] && st[2]) begin trap = 1; code = 5'b01001; end
         else if (tq && st[0] && st[3]) begin trap = 1; code = 5'b01101; end
         else if (er) ret = 1;
`ifdef EXC_EXT_INT_EN
         else if (ir && st[0] && st[4]) begin trap = 1; code = 5'b00000; end
`endif
         if (trap) begin
            cur.stl = 1;
            p1.exc = 1; p1.we = 1; p1.wc = 1; p1.ws = 1; p1.stl = 1;
            p2.redir = 1; p2.to_vec = 1;
            sched.push_back(p1);
            sched.push_back(p2);
         end else if (ret) begin
            cur.stl = 1;
            p1.ws = 1; p1.stl = 1;
            p2.redir = 1; p2.to_epc = 1;
            sched.push_back(p1);
            sched.push_back(p2);
         end
      end
      rpc = cur.to_vec ? 32'h0000_0004 : (cur.to_epc ? ep : 32'h0);
      exp_q.push_back({cur.exc, cur.we, cur.wc, cur.ws, cur.stl, cur.redir, m_pc, m_cause, rpc});
      if (r) begin
         sched.delete();
         m_pc = 32'h0;
         m_cause = 32'h0;
      end else if (trap) begin
         m_pc = ipc;
         m_cause = {25'b0, code, 2'b00};
      end
   endtask

   task automatic idle(input int n, input logic [31:0] ep);
      for (int i = 0; i < n; i++) cyc(0, 0, 0, 0, 0, 0, 32'h0, 32'h0, ep);
   endtask

   initial begin
      checks = 0; errors = 0;
      m_pc = 32'h0; m_cause = 32'h0;
      rst = 1; syscall = 0; brk = 0; teq = 0; eret = 0; int_req = 0;
      inst_pc = 0; status = 0; epc = 0;
      repeat (2) @(posedge clk);

      // Reset values, then trap entry via syscall.
      cyc(1, 0, 0, 0, 0, 0, 32'h0, 32'h0, 32'h0);
      idle(1, 32'h0);
      cyc(0, 1, 0, 0, 0, 0, 32'h0040_0010, 32'h3, 32'h0);
      idle(3, 32'h0);

      // Masked break, then enabled break.
      cyc(0, 0, 1, 0, 0, 0, 32'h0040_0020, 32'h1, 32'h0);
      idle(1, 32'h0);
      cyc(0, 0, 1, 0, 0, 0, 32'h0040_0024, 32'h5, 32'h0);
      idle(3, 32'h0);

      // Simultaneous requests, then teq during SAVE and JUMP.
      cyc(0, 1, 0, 1, 1, 0, 32'h0040_0030, 32'hF, 32'h0);
      cyc(0, 0, 0, 1, 0, 0, 32'h0040_0034, 32'hF, 32'h0);
      cyc(0, 0, 0, 1, 0, 0, 32'h0040_0038, 32'hF, 32'h0);
      idle(2, 32'h0);

      // eret returns to EPC.
      cyc(0, 0, 0, 0, 1, 0, 32'h0, 32'h0, 32'h0040_0014);
      idle(3, 32'h0040_0014);

      // Reset during SAVE abandons the sequence.
      cyc(0, 1, 0, 0, 0, 0, 32'h0040_0040, 32'h3, 32'h0);
      cyc(1, 0, 0, 0, 0, 0, 32'h0, 32'h3, 32'h0);
      idle(3, 32'h0);

`ifdef EXC_EXT_INT_EN
      // Held interrupt retaken while enabled, not once disabled.
      for (int i = 0; i < 6; i++) cyc(0, 0, 0, 0, 0, 1, 32'h0040_0050, 32'h11, 32'h0);
      for (int i = 0; i < 4; i++) cyc(0, 0, 0, 0, 0, 1, 32'h0040_0054, 32'h10, 32'h0);
      idle(3, 32'h0);
`endif

      for (int i = 0; i < 500; i++) begin
         logic r, sc, bk, tq, er, ir;
         logic [31:0] st;
         int n;
         r  = ($urandom_range(0, 39) == 0);
         sc = ($urandom_range(0, 5) == 0);
         bk = ($urandom_range(0, 5) == 0);
         tq = ($urandom_range(0, 5) == 0);
         er = ($urandom_range(0, 5) == 0);
`ifdef EXC_EXT_INT_EN
         ir = ($urandom_range(0, 5) == 0);
`else
         ir = 1'b0;
`endif
         st = $urandom;
         if ($urandom_range(0, 1) == 1) st[0] = 1'b1;
         n = int'(sc) + int'(bk) + int'(tq) + int'(er) + int'(ir);
         if (n > 1) st[4:0] = 5'h1F;
         cyc(r, sc, bk, tq, er, ir, $urandom, st, $urandom);
      end
      idle(3, 32'h0);

      repeat (2) @(negedge clk);
      #1;
      checks++;
      if (exp_q.size() != 0) begin
         errors++;
         $display("FAIL drain actual pending=%0d required 0", exp_q.size());
      end
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule
